bcd_down_counter: RTL

Presettable, synchronous, multi-digit BCD down counter. It is the counting-down complement of the team's mod-10 synchronous up counter. Each digit steps 9→0 with a ripple-free borrow into the next digit. It provides load, enable and a one-cycle borrow pulse on underflow, and is used for countdown timers and as the low end of cascaded decade chains.

---
 rtl/bcd_down_counter_if.sv | 11 +
 rtl/bcd_down_counter.sv | 49 ++++
 2 files changed

// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: control/data bundle of the BCD down counter; master drives load/en/d, slave returns q/zero/borrow
interface bcd_down_counter_if #(parameter int DIGITS = 2);
  logic load;
  logic en;
  logic [4*DIGITS-1:0] d;
  logic [4*DIGITS-1:0] q;
  logic zero;
  logic borrow;
  modport master(output load, en, d, input q, zero, borrow);
  modport slave(input load, en, d, output q, zero, borrow);
endinterface

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: presettable DIGITS-digit BCD down counter; ports clk, reset (sync active-low), bus (load/en/d in, q/zero/borrow out); BCD_DOWN_COUNTER_AUTO_RELOAD_EN wraps to last load instead of all nines
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic clk,
  input  logic reset,
  bcd_down_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  logic [W-1:0] q_r;
  logic [W-1:0] san;
  logic [W-1:0] dec;
  logic [W-1:0] wrap;
  logic [DIGITS-1:0] lz;
  logic borrow_r;
  logic zero;
  assign zero = ~|q_r;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign san[4*i+:4] = bus.d[4*i+:4] > 4'd9 ? 4'd9 : bus.d[4*i+:4];
    assign lz[i] = ~|(q_r & ((W'(1) << (4 * i)) - W'(1)));
    assign dec[4*i+:4] = lz[i] ? (q_r[4*i+:4] == 4'd0 ? 4'd9 : q_r[4*i+:4] - 4'd1) : q_r[4*i+:4];
  end
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0] rld;
  always_ff @(posedge clk)
    if (!reset) rld <= '0;
    else if (bus.load) rld <= san;
  assign wrap = rld;
`else
  assign wrap = {DIGITS{4'd9}};
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= '0;
      borrow_r <= 1'b0;
    end else if (bus.load) begin
      q_r <= san;
      borrow_r <= 1'b0;
    end else if (bus.en) begin
      q_r <= zero ? wrap : dec;
      borrow_r <= zero;
    end else begin
      borrow_r <= 1'b0;
    end
  end
  assign bus.q = q_r;
  assign bus.zero = zero;
  assign bus.borrow = borrow_r;
endmodule
